dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
Data-memory responder serving the DM_enable / DM_read / DM_write strobes issued by the multi-cycle CPU controller in its memory state.
- Owns a word-addressed storage array and performs one access per request.
- Access latency is programmable via wait states.
- Signals completion with a one-cycle DM_ready pulse, so the writeback stage can sample DM_out.
- Sits between the datapath (address and store data) and the controller (strobes).

Parameters:
DATA_WIDTH, 32, word width in bits.
ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words.
WAIT_CYCLES, 0, extra clock edges between acceptance and the access (legal range 0..7).

Ports:
clock  input  1  single system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
DM_enable  input  1  request strobe; sampled only in IDLE.
DM_read  input  1  request is a read.
DM_write  input  1  request is a write.
DM_address  input  ADDR_WIDTH  word address of the access.
DM_in  input  DATA_WIDTH  store data.
DM_out  output  DATA_WIDTH  registered read data.
DM_ready  output  1  one-cycle completion pulse.
DM_busy  output  1  high whenever the block is not in IDLE.
DM_error  output  1  valid with DM_ready; high if the request had DM_read and DM_write both set.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, wait counter = 0.
  - DM_out = 0, DM_ready = 0, DM_busy = 0, DM_error = 0.
  - Storage contents are NOT cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with DM_enable = 1, latch address, DM_in, read flag and write flag. Call this edge E0.
  - If WAIT_CYCLES = 0, perform the access at E0 and go to DONE.
  - Otherwise load counter = WAIT_CYCLES and go to WAIT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter equals 1, perform the access and go to DONE.
  - The access therefore occurs at edge E0 + WAIT_CYCLES.
- DONE:
  - DM_ready = 1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Access rules, applied at the access edge:
  - Read only: DM_out <= mem[addr].
  - Write only: mem[addr] <= latched data; DM_out unchanged.
  - Both read and write: no memory change, DM_out unchanged, DM_error = 1 during DONE.
  - Neither: no-op completion; DM_ready still pulses and DM_error = 0.
- DM_error is 0 whenever DM_ready is 0.
- DM_out holds the last read value until the next successful read.
- DM_enable in WAIT or DONE is ignored; it is neither queued nor treated as an error. The earliest a new request can be accepted is the edge after DONE.
- DM_read, DM_write, DM_address and DM_in may change freely after E0; only the latched copies are used.
- A write followed by a read to the same address returns the newly written data.
- Reset asserted in WAIT aborts the request: no memory write occurs and DM_ready never pulses.
- Address arithmetic: full-range index, so every address is in range and no wrap handling is needed.
- Latency from E0 to the DM_ready cycle is WAIT_CYCLES + 1 edges. With WAIT_CYCLES = 0, a request strobed in the controller's memory state yields DM_ready and DM_out valid during its writeback state.

Decomposition:
- Shared package dm_defs: the state encoding constants (IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10) and the WAIT_CYCLES upper bound.
- One sub-module, dm_storage: synchronous-write, synchronous-read array with ports clock, we, re, addr, wdata, rdata. It has no reset.
- dm_responder keeps the FSM, the counter, the request latches and the output registers.

Test Plan:
- Reset mid-write: WAIT_CYCLES = 3, write 0xDEADBEEF to address 5, assert reset on the second WAIT edge -> DM_ready never pulses; a later read of address 5 does not return 0xDEADBEEF (pre-load 0x11111111 and expect 0x11111111).
- Write then read, zero wait: WAIT_CYCLES = 0, write 0x12345678 to address 0x3FF, then read 0x3FF -> each DM_ready pulses the cycle after its strobe edge; DM_out = 0x12345678.
- Wait-state latency: WAIT_CYCLES = 3, read address 7 pre-loaded with 0xA5A5A5A5 -> DM_ready high exactly 4 edges after E0; DM_busy high for 4 cycles; DM_out = 0xA5A5A5A5.
- Ignore while busy: WAIT_CYCLES = 2, second DM_enable write of 0xFFFFFFFF to address 9 issued during WAIT -> address 9 unchanged; only one DM_ready pulse.
- Both flags set: DM_read = DM_write = 1, address 4, DM_in = 0x0 -> DM_error = 1 with DM_ready; address 4 and DM_out unchanged.
- Neither flag set: DM_enable with DM_read = DM_write = 0 -> DM_ready pulses, DM_error = 0, no state change in memory.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder:
// FSM state encoding and the wait-state bound.
package dm_defs;

  localparam int unsigned WAIT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dm_state_e;

endpackage

// File: rtl/dm_storage.sv
// Word-addressed storage array: synchronous write,
// synchronous read, no reset so contents survive it.
module dm_storage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: latches one request, waits
// WAIT_CYCLES edges, accesses storage, pulses DM_ready.
module dm_responder
  import dm_defs::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  DM_enable,
  input  logic                  DM_read,
  input  logic                  DM_write,
  input  logic [ADDR_WIDTH-1:0] DM_address,
  input  logic [DATA_WIDTH-1:0] DM_in,
  output logic [DATA_WIDTH-1:0] DM_out,
  output logic                  DM_ready,
  output logic                  DM_busy,
  output logic                  DM_error
);

  dm_state_e             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  access;
  logic                  mem_we, mem_re;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_only_q;

  assign rd_only_q = rd_q & ~wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    out_d   = out_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DM_enable) begin
          addr_d = DM_address;
          data_d = DM_in;
          rd_d   = DM_read;
          wr_d   = DM_write;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = 3'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        // Capture the read word so it persists past DONE.
        if (rd_only_q) out_d = rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands come from the _d side so a zero-wait access
  // uses the request seen on the acceptance edge.
  assign mem_we = access & wr_d & ~rd_d;
  assign mem_re = access & rd_d & ~wr_d;

  dm_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_storage (
    .clock(clock),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr_d),
    .wdata(data_d),
    .rdata(rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      out_q   <= out_d;
    end
  end

  assign DM_ready = (state_q == DONE);
  assign DM_busy  = (state_q != IDLE);
  assign DM_error = (state_q == DONE) & rd_q & wr_q;
  assign DM_out   = ((state_q == DONE) && rd_only_q) ? rdata : out_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances with
// WAIT_CYCLES of 0, 2 and 3 share stimulus.
module tb_dm_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [9:0]  addr  = '0;
  logic [31:0] din   = '0;
  logic        en   [3];
  logic [31:0] out  [3];
  logic        rdy  [3];
  logic        busy [3];
  logic        err  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dm_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset(reset), .DM_enable(en[0]),
    .DM_read(rd), .DM_write(wr), .DM_address(addr),
    .DM_in(din), .DM_out(out[0]), .DM_ready(rdy[0]),
    .DM_busy(busy[0]), .DM_error(err[0]));

  dm_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clock(clock), .reset(reset), .DM_enable(en[1]),
    .DM_read(rd), .DM_write(wr), .DM_address(addr),
    .DM_in(din), .DM_out(out[1]), .DM_ready(rdy[1]),
    .DM_busy(busy[1]), .DM_error(err[1]));

  dm_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clock(clock), .reset(reset), .DM_enable(en[2]),
    .DM_read(rd), .DM_write(wr), .DM_address(addr),
    .DM_in(din), .DM_out(out[2]), .DM_ready(rdy[2]),
    .DM_busy(busy[2]), .DM_error(err[2]));

  // Drive a request into instance k; returns 1 time unit after E0.
  task automatic issue(input int k, input logic r, input logic w,
                       input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    rd = r; wr = w; addr = a; din = d;
    en[k] = 1'b1;
    @(posedge clock); #1;
    en[k] = 1'b0;
  endtask

  // n = edges from E0 to the first DM_ready sample; bc = busy samples.
  task automatic wait_ready(input int k, output int n, output int bc);
    n  = 1;
    bc = busy[k] ? 1 : 0;
    while (!rdy[k] && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (busy[k]) bc++;
    end
    if (!rdy[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout inst=%0d: DM_ready never seen", k);
    end
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  task automatic do_req(input int k, input logic r, input logic w,
                        input logic [9:0] a, input logic [31:0] d);
    int n, bc;
    issue(k, r, w, a, d);
    wait_ready(k, n, bc);
    step();
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (rdy[k] !== 1'b0 || busy[k] !== 1'b0 ||
          err[k] !== 1'b0 || out[k] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset inst=%0d: rdy=%b busy=%b err=%b out=%h want 0 0 0 0",
                 k, rdy[k], busy[k], err[k], out[k]);
      end
    end
    step(); step();
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic test_zero_wait;
    int n, bc;
    issue(0, 1'b0, 1'b1, 10'h3FF, 32'h12345678);
    wait_ready(0, n, bc);
    n_cmp++;
    if (n !== 1) begin
      n_bad++; $display("FAIL zw_write_lat: got %0d want 1", n);
    end
    n_cmp++;
    if (out[0] !== 32'h0) begin
      n_bad++; $display("FAIL zw_write_out: got %h want 00000000", out[0]);
    end
    step();
    issue(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
    wait_ready(0, n, bc);
    n_cmp++;
    if (n !== 1 || out[0] !== 32'h12345678 || err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_read: lat=%0d out=%h err=%b want 1 12345678 0",
               n, out[0], err[0]);
    end
    step();
    n_cmp++;
    if (rdy[0] !== 1'b0 || out[0] !== 32'h12345678) begin
      n_bad++;
      $display("FAIL zw_hold: rdy=%b out=%h want 0 12345678", rdy[0], out[0]);
    end
  endtask

  task automatic test_latency;
    int n, bc;
    do_req(2, 1'b0, 1'b1, 10'd7, 32'hA5A5A5A5);
    issue(2, 1'b1, 1'b0, 10'd7, 32'h0);
    rd = 1'b0; addr = 10'd0;
    wait_ready(2, n, bc);
    n_cmp++;
    if (n !== 4 || bc !== 4) begin
      n_bad++;
      $display("FAIL lat_w3: edges=%0d busy=%0d want 4 4", n, bc);
    end
    n_cmp++;
    if (out[2] !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL lat_out: got %h want a5a5a5a5", out[2]);
    end
    step();
    n_cmp++;
    if (busy[2] !== 1'b0 || out[2] !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL lat_idle: busy=%b out=%h want 0 a5a5a5a5", busy[2], out[2]);
    end
  endtask

  task automatic test_ignore_busy;
    int pulses, n, bc;
    do_req(1, 1'b0, 1'b1, 10'd9, 32'h99999999);
    issue(1, 1'b0, 1'b1, 10'd8, 32'h88888888);
    rd = 1'b0; wr = 1'b1; addr = 10'd9; din = 32'hFFFFFFFF;
    en[1] = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (rdy[1]) pulses++;
      if (i == 2) en[1] = 1'b0;
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++; $display("FAIL busy_pulses: got %0d want 1", pulses);
    end
    issue(1, 1'b1, 1'b0, 10'd9, 32'h0);
    wait_ready(1, n, bc);
    n_cmp++;
    if (out[1] !== 32'h99999999) begin
      n_bad++; $display("FAIL busy_addr9: got %h want 99999999", out[1]);
    end
    step();
    issue(1, 1'b1, 1'b0, 10'd8, 32'h0);
    wait_ready(1, n, bc);
    n_cmp++;
    if (out[1] !== 32'h88888888 || n !== 3) begin
      n_bad++;
      $display("FAIL busy_addr8: out=%h lat=%0d want 88888888 3", out[1], n);
    end
    step();
  endtask

  task automatic test_both_flags;
    int n, bc;
    do_req(0, 1'b0, 1'b1, 10'd4, 32'h44444444);
    do_req(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
    issue(0, 1'b1, 1'b1, 10'd4, 32'h0);
    wait_ready(0, n, bc);
    n_cmp++;
    if (err[0] !== 1'b1 || out[0] !== 32'h12345678 || n !== 1) begin
      n_bad++;
      $display("FAIL both: err=%b out=%h lat=%0d want 1 12345678 1",
               err[0], out[0], n);
    end
    step();
    n_cmp++;
    if (err[0] !== 1'b0) begin
      n_bad++; $display("FAIL both_err_clear: got %b want 0", err[0]);
    end
    issue(0, 1'b1, 1'b0, 10'd4, 32'h0);
    wait_ready(0, n, bc);
    n_cmp++;
    if (out[0] !== 32'h44444444) begin
      n_bad++; $display("FAIL both_mem: got %h want 44444444", out[0]);
    end
    step();
  endtask

  task automatic test_neither;
    int n, bc;
    issue(0, 1'b0, 1'b0, 10'd4, 32'hCAFEF00D);
    wait_ready(0, n, bc);
    n_cmp++;
    if (n !== 1 || err[0] !== 1'b0 || out[0] !== 32'h44444444) begin
      n_bad++;
      $display("FAIL neither: lat=%0d err=%b out=%h want 1 0 44444444",
               n, err[0], out[0]);
    end
    step();
    do_req(0, 1'b1, 1'b0, 10'd0, 32'h0);
    issue(0, 1'b1, 1'b0, 10'd4, 32'h0);
    wait_ready(0, n, bc);
    n_cmp++;
    if (out[0] !== 32'h44444444) begin
      n_bad++; $display("FAIL neither_mem: got %h want 44444444", out[0]);
    end
    step();
  endtask

  task automatic test_reset_mid_write;
    int n, bc, pulses;
    do_req(2, 1'b0, 1'b1, 10'd5, 32'h11111111);
    issue(2, 1'b0, 1'b1, 10'd5, 32'hDEADBEEF);
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (busy[2] !== 1'b0 || rdy[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: busy=%b rdy=%b want 0 0", busy[2], rdy[2]);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rdy[2]) pulses++;
    end
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rdy[2]) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL rst_pulses: got %0d want 0", pulses);
    end
    issue(2, 1'b1, 1'b0, 10'd5, 32'h0);
    wait_ready(2, n, bc);
    n_cmp++;
    if (out[2] !== 32'h11111111) begin
      n_bad++; $display("FAIL rst_mem: got %h want 11111111", out[2]);
    end
    step();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) en[k] = 1'b0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_ignore_busy();
    test_both_flags();
    test_neither();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
